// File: rtl/loop_err_pkg.sv
// loop_err_pkg: shared widths and loop-error limits for the integrate-and-dump stage.
// Revision 1.0
`default_nettype none

package loop_err_pkg;
  localparam int IN_WIDTH_DEF  = 12;
  localparam int CNT_WIDTH_DEF = 8;
  localparam int ACC_WIDTH_DEF = 24;
  localparam int SHIFT_WIDTH   = 4;
  localparam int ERR_WIDTH     = 8;
  localparam int ERR_MAX       = 127;
  localparam int ERR_MIN       = -128;
endpackage

`default_nettype wire

// File: rtl/loop_err_sat.sv
// loop_err_sat: combinational round/shift/saturate of the dumped sum to an 8-bit loop error.
// Revision 1.0 -- LOOP_ERR_ROUND_EN selects round-half-up instead of floor truncation.
`default_nettype none

module loop_err_sat
  import loop_err_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic signed [ACC_WIDTH-1:0]   i_total,
  input  logic        [SHIFT_WIDTH-1:0] i_shift,
  output logic        [ERR_WIDTH-1:0]   o_err,
  output logic                          o_clip
);
  localparam int c_W = ACC_WIDTH + 1;
  localparam logic signed [ACC_WIDTH:0] c_MAX = c_W'(ERR_MAX);
  localparam logic signed [ACC_WIDTH:0] c_MIN = c_W'(ERR_MIN);

  // One guard bit so the rounding bias can never wrap the sum.
  logic signed [ACC_WIDTH:0] w_bias;
  logic signed [ACC_WIDTH:0] w_rnd;
  logic signed [ACC_WIDTH:0] w_scaled;

  always_comb begin
    w_bias = '0;
`ifdef LOOP_ERR_ROUND_EN
    if (i_shift != '0) w_bias[i_shift - 4'd1] = 1'b1;
`endif
    w_rnd    = {i_total[ACC_WIDTH-1], i_total} + w_bias;
    w_scaled = w_rnd >>> i_shift;
    o_clip   = 1'b0;
    o_err    = w_scaled[ERR_WIDTH-1:0];
    if (w_scaled > c_MAX) begin
      o_err  = 8'h7F;
      o_clip = 1'b1;
    end else if (w_scaled < c_MIN) begin
      o_err  = 8'h80;
      o_clip = 1'b1;
    end
  end
endmodule

`default_nettype wire

// File: rtl/loop_error_decim.sv
// loop_error_decim: decimating integrate-and-dump of discriminator samples, issuing a strobed 8-bit loop error.
// Revision 1.0 -- build option LOOP_ERR_ROUND_EN (rounding in loop_err_sat).
`default_nettype none

module loop_error_decim
  import loop_err_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sampleEn,
  input  logic [IN_WIDTH-1:0]    discError,
  input  logic [CNT_WIDTH-1:0]   decimCount,
  input  logic [SHIFT_WIDTH-1:0] errShift,
  input  logic                   freeze,
  output logic [ERR_WIDTH-1:0]   errorOut,
  output logic                   errorEn,
  output logic                   satPulse
);
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic        [CNT_WIDTH-1:0] r_cnt;
  logic        [ERR_WIDTH-1:0] r_err;
  logic                        r_err_en;
  logic                        r_sat;

  logic signed [ACC_WIDTH-1:0] w_ext;
  logic signed [ACC_WIDTH-1:0] w_total;
  logic                        w_dump;
  logic        [ERR_WIDTH-1:0] w_err;
  logic                        w_clip;

  assign w_ext   = {{(ACC_WIDTH-IN_WIDTH){discError[IN_WIDTH-1]}}, discError};
  assign w_total = r_acc + w_ext;
  // >= so that lowering decimCount below the current count dumps on the next strobe.
  assign w_dump  = sampleEn && (r_cnt >= decimCount);

  loop_err_sat #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_sat (
    .i_total (w_total),
    .i_shift (errShift),
    .o_err   (w_err),
    .o_clip  (w_clip)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_err    <= '0;
      r_err_en <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      r_err_en <= 1'b0;
      r_sat    <= 1'b0;
      if (freeze) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_dump) begin
        r_acc    <= '0;
        r_cnt    <= '0;
        r_err    <= w_err;
        r_err_en <= 1'b1;
        r_sat    <= w_clip;
      end else if (sampleEn) begin
        r_acc <= w_total;
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign errorOut = r_err;
  assign errorEn  = r_err_en;
  assign satPulse = r_sat;
endmodule

`default_nettype wire

// File: tb/tb_loop_error_decim.sv
// tb_loop_error_decim: directed vectors with a queue scoreboard checked on every errorEn strobe.
// Revision 1.0
`default_nettype none

module tb_loop_error_decim;
  logic        clk = 1'b0;
  logic        reset;
  logic        sampleEn;
  logic [11:0] discError;
  logic [7:0]  decimCount;
  logic [3:0]  errShift;
  logic        freeze;
  logic [7:0]  errorOut;
  logic        errorEn;
  logic        satPulse;

  typedef struct packed {
    logic [7:0] err;
    logic       sat;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  loop_error_decim dut (
    .clk        (clk),
    .reset      (reset),
    .sampleEn   (sampleEn),
    .discError  (discError),
    .decimCount (decimCount),
    .errShift   (errShift),
    .freeze     (freeze),
    .errorOut   (errorOut),
    .errorEn    (errorEn),
    .satPulse   (satPulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic expect_out(input logic [7:0] e, input logic s);
    exp_t x;
    x.err = e;
    x.sat = s;
    q.push_back(x);
  endtask

  // Inputs change 1 time unit after the rising edge; each call presents one cycle.
  task automatic sample(input int v);
    sampleEn  = 1'b1;
    discError = 12'(v);
    @(posedge clk); #1;
    sampleEn  = 1'b0;
  endtask

  task automatic idle(input int n);
    sampleEn = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: every strobe must match the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && satPulse && !errorEn) check("satPulse_without_errorEn", 1, 0);
      if (!reset && errorEn) begin
        if (q.size() == 0) check("unexpected_errorEn", 1, 0);
        else begin
          e = q.pop_front();
          check("errorOut", errorOut, e.err);
          check("satPulse", satPulse, e.sat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; sampleEn = 1'b0; discError = '0;
    decimCount = 8'd3; errShift = 4'd2; freeze = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_errorOut", errorOut, 8'h00);
    check("reset_errorEn", errorEn, 0);
    check("reset_satPulse", satPulse, 0);
    reset = 1'b0;
    idle(2);

    // 40 >>> 2 = 10
    sample(10); sample(10); sample(10);
    expect_out(8'h0A, 1'b0); sample(10);
    idle(3);

    // Positive and negative clipping
    errShift = 4'd0;
    sample(2047); sample(2047); sample(2047);
    expect_out(8'h7F, 1'b1); sample(2047);
    sample(-2048); sample(-2048); sample(-2048);
    expect_out(8'h80, 1'b1); sample(-2048);
    idle(3);

    // Sum 3 >> 2: rounding vs floor; sum -3 gives -1 either way
    errShift = 4'd2;
    sample(1); sample(1); sample(1);
`ifdef LOOP_ERR_ROUND_EN
    expect_out(8'h01, 1'b0);
`else
    expect_out(8'h00, 1'b0);
`endif
    sample(0);
    sample(-1); sample(-1); sample(-1);
    expect_out(8'hFF, 1'b0); sample(0);
    idle(3);

    // No decimation, gapped strobes
    decimCount = 8'd0; errShift = 4'd0;
    expect_out(8'h05, 1'b0); sample(5);
    idle(2);
    expect_out(8'hF9, 1'b0); sample(-7);
    idle(3);

    // Freeze discards the partial frame and blocks dumps
    decimCount = 8'd7; errShift = 4'd3;
    sample(4); sample(4); sample(4);
    freeze = 1'b1; sampleEn = 1'b1; discError = 12'd4;
    @(negedge clk);
    check("freeze_hold_errorOut", errorOut, 8'hF9);
    @(posedge clk); #1;
    freeze = 1'b0; sampleEn = 1'b0;
    for (int i = 0; i < 7; i++) sample(4);
    idle(2);
    expect_out(8'h04, 1'b0); sample(4);
    idle(3);

    // Lowering decimCount mid-frame forces a dump on the next strobe: 48 >>> 3 = 6
    for (int i = 0; i < 5; i++) sample(8);
    decimCount = 8'd2;
    expect_out(8'h06, 1'b0); sample(8);
    idle(2);

    // Reset mid-frame clears outputs and the partial sum
    decimCount = 8'd7; errShift = 4'd0;
    sample(100); sample(100); sample(100);
    reset = 1'b1;
    #2;
    check("midreset_errorOut", errorOut, 8'h00);
    check("midreset_errorEn", errorEn, 0);
    check("midreset_satPulse", satPulse, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 7; i++) sample(1);
    idle(2);
    expect_out(8'h08, 1'b0); sample(1);
    idle(4);

    check("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/loop_error_decim.md
# loop_error_decim

Decimating integrate-and-dump stage ahead of the loop-filter lag/lead gain blocks. It sums signed phase/frequency discriminator samples over a programmable number of input strobes and scales the sum by a programmable right shift. The result is saturated to the signed 8-bit loop error format. Each result is issued with a one-cycle strobe that drives the loop filter's clkEn, so the whole filter runs at the decimated rate.

## Interface
- IN_WIDTH, 12, discriminator sample width (signed two's complement)
- CNT_WIDTH, 8, decimation counter width
- ACC_WIDTH, 24, accumulator width; must be ≥ IN_WIDTH+CNT_WIDTH
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- sampleEn  in  1  qualifies discError; one sample per high cycle
- discError  in  IN_WIDTH  signed discriminator sample
- decimCount  in  CNT_WIDTH  dump period minus one (N = decimCount+1 samples per output)
- errShift  in  4  arithmetic right shift applied to the dumped sum (0–15)
- freeze  in  1  synchronous hold/clear of the integrator
- errorOut  out  8  signed loop error, held between dumps
- errorEn  out  1  one-cycle strobe, errorOut new this cycle
- satPulse  out  1  one-cycle strobe coincident with errorEn when the result was clipped

## Operation
- Sample counter cnt counts sampleEn strobes. The accumulator acc holds the running sum of sign-extended discError.
- Ordinary sample, sampleEn=1 and cnt < decimCount: acc ← acc + discError; cnt ← cnt+1.
- Dump sample, sampleEn=1 and cnt ≥ decimCount:
  - total = acc + discError at full ACC_WIDTH.
  - scaled = total >>> errShift, arithmetic.
  - Saturate scaled to [−128, +127] and register the result to errorOut.
  - errorEn ← 1. satPulse ← 1 if clipped.
  - acc ← 0; cnt ← 0.
- Using ≥ guarantees a dump on the next strobe when decimCount is lowered below the current cnt mid-frame. Raising decimCount mid-frame extends the current frame.
- decimCount=0: every sample is a dump. No accumulation takes place.
- freeze=1: acc ← 0, cnt ← 0, no dump. errorEn and satPulse are 0. errorOut keeps its last value. freeze overrides sampleEn in the same cycle.
- No overflow is possible in acc given the ACC_WIDTH constraint. Clipping occurs only at the 8-bit output.
- errShift is sampled at the dump cycle only.

## Timing
- Reset values: errorOut=0x00, errorEn=0, satPulse=0; acc=0, cnt=0.
- Latency: errorOut, errorEn and satPulse update on the clock edge after the cycle in which the dump sample is presented. errorEn is high for exactly one clk.
- The maximum errorEn rate equals the sampleEn rate (decimCount=0). Back-to-back sampleEn every clk is supported.
- Reset mid-frame discards the partial sum. The first output after reset needs a full N samples.
- errorEn is never asserted without a preceding sampleEn dump.

## Configuration
- LOOP_ERR_ROUND_EN defined: round half toward +∞ before the shift. When errShift>0, add 2^(errShift−1) to total, then shift. When errShift=0 the add is skipped.
- Not defined: truncate. A plain arithmetic shift gives floor behaviour.
- Saturation is applied after rounding in both builds.

## Structure
- Shared package loop_err_pkg holds:
  - the default widths;
  - the ERR_MAX (+127) and ERR_MIN (−128) constants;
  - the errShift width.
- One sub-module, loop_err_sat: combinational round/shift/saturate of the ACC_WIDTH total to 8 bits, with a clip flag. The parent holds the counter, accumulator, control and output registers.

## Test plan
- decimCount=3, errShift=2, samples 10,10,10,10 on consecutive clks → errorOut=0x0A with a single errorEn one clk after the 4th sample; satPulse=0.
- decimCount=3, errShift=0, four samples of +2047 → errorOut=0x7F, satPulse=1. Then four samples of −2048 → errorOut=0x80, satPulse=1.
- decimCount=3, errShift=2, samples 1,1,1,0 (sum 3):
  - LOOP_ERR_ROUND_EN defined → errorOut=0x01;
  - not defined → 0x00.
  - Sum −3 gives 0xFF in both builds.
- decimCount=0, errShift=0, samples 5,−7 with sampleEn gapped → errorOut=0x05 then 0xF9, errorEn once per sample.
- decimCount=7, after 3 samples assert freeze for 1 clk, then 8 samples of 4, errShift=3 → no errorEn during freeze; next errorOut=0x04 only after the 8th post-freeze sample.
- decimCount=7, after 5 samples change decimCount to 2 → dump on the 6th sample. Assert reset mid-frame → outputs return to 0 and the partial sum is discarded.
